// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencing controller.
// Holds the command encodings, the controller state type and the datapath widths.
package alu_seq_pkg;

  localparam int DATA_W    = 8;
  localparam int ALU_SEL_W = 3;

  // Command kinds carried on cmd_kind
  localparam logic [1:0] KIND_LOAD  = 2'b00;
  localparam logic [1:0] KIND_EXEC  = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_CLEAR = 2'b11;

  // Controller states: waiting for a command, iterating the ALU, offering a result
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller.
// Keeps an 8-bit accumulator and drives an external combinational ALU.
// LOAD and CLEAR update the accumulator in place. READ returns the accumulator.
// EXEC applies one latched ALU operation cmd_rep+1 times, feeding the result back
// into the accumulator each cycle, and then returns the final value and carry.
// The block never decodes ALU semantics; the select code is only forwarded.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_kind,
  input  logic [2:0]           cmd_sel,
  input  logic [7:0]           cmd_data,
  input  logic [REP_W-1:0]     cmd_rep,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic                 res_cout,
  output logic                 busy,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_result,
  input  logic                 alu_cout
);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_W-1:0]      acc;
  logic [DATA_W-1:0]      acc_nxt;
  logic                   cout_r;
  logic                   cout_nxt;
  logic [REP_W-1:0]       cnt;
  logic [REP_W-1:0]       cnt_nxt;
  logic [ALU_SEL_W-1:0]   sel_r;
  logic [ALU_SEL_W-1:0]   sel_nxt;
  logic [DATA_W-1:0]      data_r;
  logic [DATA_W-1:0]      data_nxt;
  logic                   cmd_fire;

  // Handshake and status flags follow directly from the current state
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    res_valid = (state == ST_RESP);
    busy      = (state != ST_IDLE);
    cmd_fire  = cmd_valid && (state == ST_IDLE);
    res_data  = acc;
    res_cout  = cout_r;
  end

  // ALU operands: live operands only while iterating, otherwise a quiet zero B/select
  always_comb begin
    alu_a   = acc;
    alu_b   = '0;
    alu_sel = '0;
    if (state == ST_EXEC) begin
      alu_b   = data_r;
      alu_sel = sel_r;
    end
  end

  // Next-state and datapath update decisions
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cout_nxt  = cout_r;
    cnt_nxt   = cnt;
    sel_nxt   = sel_r;
    data_nxt  = data_r;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd_kind)
            KIND_LOAD: begin
              acc_nxt = cmd_data;
            end
            KIND_EXEC: begin
              sel_nxt   = cmd_sel;
              data_nxt  = cmd_data;
              cnt_nxt   = cmd_rep;
              state_nxt = ST_EXEC;
            end
            KIND_READ: begin
              cout_nxt  = 1'b0;
              state_nxt = ST_RESP;
            end
            default: begin
              acc_nxt  = '0;
              cout_nxt = 1'b0;
            end
          endcase
        end
      end
      ST_EXEC: begin
        acc_nxt  = alu_result;
        cout_nxt = alu_cout;
        if (cnt == '0) begin
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - REP_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cout_r <= 1'b0;
      cnt    <= '0;
      sel_r  <= '0;
      data_r <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cout_r <= cout_nxt;
      cnt    <= cnt_nxt;
      sel_r  <= sel_nxt;
      data_r <= data_nxt;
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: REP_W, 4, width of repeat count (max 2^REP_W iterations per EXEC).
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst  in  1  synchronous reset, active-high.
REQ-004 Port: cmd_valid  in  1  command offered.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 Port: cmd_kind  in  2  00 LOAD, 01 EXEC, 10 READ, 11 CLEAR.
REQ-007 Port: cmd_sel  in  3  ALU operation select for EXEC, passed unmodified to alu_sel.
REQ-008 Port: cmd_data  in  8  LOAD value / EXEC B operand.
REQ-009 Port: cmd_rep  in  REP_W  EXEC repeat count; iterations = cmd_rep+1.
REQ-010 Port: res_valid  out  1  result offered.
REQ-011 Port: res_ready  in  1  result consumed when res_valid & res_ready.
REQ-012 Port: res_data  out  8  accumulator value.
REQ-013 Port: res_cout  out  1  carry of last EXEC iteration (0 for READ).
REQ-014 Port: busy  out  1  high in any state but IDLE.
REQ-015 Ports: alu_a out 8, alu_b out 8, alu_sel out 3, alu_result in 8, alu_cout in 1 -- drive/observe external combinational alu_8bit.

Function
REQ-016 States SHALL be IDLE, EXEC, RESP; cmd_ready = (state==IDLE); res_valid = (state==RESP).
REQ-017 IDLE, LOAD accepted: acc <= cmd_data next edge; stay IDLE; no result produced.
REQ-018 IDLE, CLEAR accepted: acc <= 0, cout_r <= 0; stay IDLE; no result.
REQ-019 IDLE, READ accepted: cout_r <= 0; go RESP (res_valid high the following cycle).
REQ-020 IDLE, EXEC accepted: latch sel, data, cnt <= cmd_rep; go EXEC.
REQ-021 EXEC: alu_a = acc, alu_b = latched data, alu_sel = latched sel; each edge acc <= alu_result, cout_r <= alu_cout.
REQ-022 EXEC: if cnt==0 go RESP, else cnt <= cnt-1; EXEC occupies exactly cmd_rep+1 cycles; res_valid first high cmd_rep+2 cycles after accept edge.
REQ-023 Outside EXEC, alu_a = acc, alu_b = 0, alu_sel = 0 (ALU outputs ignored).
REQ-024 RESP: res_data = acc, res_cout = cout_r, held stable while res_ready low; on handshake go IDLE.
REQ-025 No command bypass: a command presented during the RESP handshake cycle is accepted no earlier than the next cycle (IDLE).
REQ-026 All 8 cmd_sel codes SHALL be forwarded; no decoding of ALU semantics inside block.
REQ-027 Accumulator width 8; alu_result wraps naturally; no saturation.

Reset
REQ-028 rst high at edge: state IDLE, acc 0, cout_r 0, cnt 0, latched sel/data 0; cmd_ready 1, res_valid 0, busy 0 in following cycle.
REQ-029 rst asserted mid-EXEC or mid-RESP SHALL abort the command; no result is delivered.
REQ-030 rst overrides a simultaneous command handshake; that command is dropped.

Structure
REQ-031 Shared package alu_seq_pkg: cmd_kind encoding constants, state enum, ALU_SEL_W=3, DATA_W=8.
REQ-032 Single flat module, no sub-modules; alu_8bit instantiated alongside it by the top wrapper.

Verification (bench ALU model: sel 000 -> A+B with Cout, sel 001 -> A-B)
REQ-033 Reset, then LOAD 0x05, READ, res_ready=1 -> res_data 0x05, res_cout 0, busy low afterwards.
REQ-034 LOAD 0x10, EXEC sel 000 data 0x03 rep 3 -> exactly 4 EXEC cycles, res_data 0x1C, res_cout 0, res_valid 5 cycles after accept.
REQ-035 LOAD 0xF0, EXEC sel 000 data 0x20 rep 0 -> res_data 0x10, res_cout 1 (wrap).
REQ-036 EXEC result with res_ready low 10 cycles -> res_valid/res_data stable, cmd_ready 0, cmd_valid ignored; released on res_ready.
REQ-037 rst pulse during EXEC rep 15 -> no res_valid, READ afterwards returns 0x00.
REQ-038 EXEC rep 15 data 0x01 from acc 0x00 -> res_data 0x10 after 16 EXEC cycles; CLEAR then READ -> 0x00.
